// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request/status handshake and PS/2 pin signals of the host transmitter.
interface ps2_host_tx_if;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       i_ps2c_in;
    logic       i_ps2d_in;
    logic       o_ps2c_oe;
    logic       o_ps2d_oe;
    logic       o_busy;
    logic       o_done;
    logic       o_ack_ok;
    logic       o_timeout;
    modport master (
        output i_tx_data, i_tx_valid, i_ps2c_in, i_ps2d_in,
        input  o_tx_ready, o_ps2c_oe, o_ps2d_oe, o_busy, o_done, o_ack_ok, o_timeout
    );
    modport slave (
        input  i_tx_data, i_tx_valid, i_ps2c_in, i_ps2d_in,
        output o_tx_ready, o_ps2c_oe, o_ps2d_oe, o_busy, o_done, o_ack_ok, o_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte sender with inhibit, request-to-send, ACK check and timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic          clk,
    input logic          rst_n,
    ps2_host_tx_if.slave bus
);
    localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, FINISH} state_t;
    state_t        r_state, w_next;
    logic [1:0]    r_c_sync, r_d_sync;
    logic          r_c_prev;
    logic [10:0]   r_frame;
    logic [3:0]    r_edges;
    logic [CW-1:0] r_cnt;
    logic          r_ack;
    logic          w_c, w_d, w_fall, w_accept, w_to;
    assign w_c        = r_c_sync[1];
    assign w_d        = r_d_sync[1];
    assign w_fall     = r_c_prev & ~w_c;
    assign w_accept   = r_state == IDLE && bus.i_tx_valid;
    assign w_to       = (r_state inside {REQ, SEND, ACK, FINISH}) && r_cnt == CW'(TIMEOUT_CYCLES);
    assign bus.o_tx_ready = r_state == IDLE;
    assign bus.o_busy     = r_state != IDLE;
    assign bus.o_ack_ok   = r_ack;
    always_comb begin
        w_next        = r_state;
        bus.o_ps2c_oe = 1'b0;
        bus.o_ps2d_oe = 1'b0;
        bus.o_done    = 1'b0;
        bus.o_timeout = 1'b0;
        if (w_to) begin
            w_next        = IDLE;
            bus.o_done    = 1'b1;
            bus.o_timeout = 1'b1;
        end else begin
            case (r_state)
                IDLE:    w_next = bus.i_tx_valid ? INHIBIT : IDLE;
                INHIBIT: begin
                    bus.o_ps2c_oe = 1'b1;
                    w_next        = r_cnt == CW'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
                end
                REQ: begin
                    bus.o_ps2c_oe = 1'b1;
                    bus.o_ps2d_oe = 1'b1;
                    w_next        = SEND;
                end
                SEND: begin
                    bus.o_ps2d_oe = ~r_frame[0];
                    w_next        = w_fall && r_edges == 4'd9 ? ACK : SEND;
                end
                ACK:     w_next = w_fall ? FINISH : ACK;
                FINISH: begin
                    bus.o_done = w_c & w_d;
                    w_next     = w_c && w_d ? IDLE : FINISH;
                end
                default: w_next = IDLE;
            endcase
        end
    end
    // one counter times the inhibit phase, then restarts at REQ as the transfer timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_c_sync <= '1;
            r_d_sync <= '1;
            r_c_prev <= 1'b1;
            r_frame  <= '1;
            r_edges  <= '0;
            r_cnt    <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_c_sync <= {r_c_sync[0], bus.i_ps2c_in};
            r_d_sync <= {r_d_sync[0], bus.i_ps2d_in};
            r_c_prev <= w_c;
            r_cnt    <= (r_state == IDLE || (r_state == INHIBIT && w_next == REQ)) ? '0 : r_cnt + 1'b1;
            r_ack    <= (w_accept || w_to) ? 1'b0 : (r_state == ACK && w_fall) ? ~w_d : r_ack;
            if (w_accept) begin
                r_frame <= {1'b1, ~^bus.i_tx_data, bus.i_tx_data, 1'b0};
                r_edges <= '0;
            end else if (r_state == SEND && w_fall) begin
                r_frame <= {1'b1, r_frame[10:1]};
                r_edges <= r_edges + 1'b1;
            end
        end
    end
endmodule
